lane_to_fifo_bridge: RTL

LANE_TO_FIFO_BRIDGE -- requirements
Module: lane_to_fifo_bridge

---
 rtl/lane_to_fifo_bridge.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/lane_to_fifo_bridge.sv
// lane_to_fifo_bridge
// Turns the byte stream of a receive lane into FIFO writes that carry an
// end-of-packet marker. The lane cannot be stalled, so each byte waits in a
// one-byte hold register until the bridge knows whether it is the last byte
// of its burst. That byte is then written with eop=1. If the downstream FIFO
// is full at a write decision, the byte is lost and the rest of the burst is
// discarded.
module lane_to_fifo_bridge #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lane_active,
  input  logic              lane_valid,
  input  logic [DATA_W-1:0] lane_data,
  input  logic              fifo_full,
  output logic              fifo_write,
  output logic [DATA_W:0]   fifo_data,
  input  logic [15:0]       rx_timeout,
  input  logic              err_clr,
  output logic              overflow_err,
  output logic              timeout_err,
  output logic              pkt_done,
  output logic [15:0]       last_pkt_len
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t              state_q,      state_d;
  logic                hold_vld_q,   hold_vld_d;
  logic [DATA_W-1:0]   hold_data_q,  hold_data_d;
  logic [15:0]         idle_cnt_q,   idle_cnt_d;
  logic [15:0]         byte_cnt_q,   byte_cnt_d;
  logic                fifo_write_q, fifo_write_d;
  logic [DATA_W:0]     fifo_data_q,  fifo_data_d;
  logic                pkt_done_q,   pkt_done_d;
  logic                ovf_q,        ovf_d;
  logic                tmo_q,        tmo_d;
  logic [15:0]         len_q,        len_d;

  logic                ovf_set;
  logic                tmo_set;
  logic [15:0]         idle_inc;
  logic                timeout_hit;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Next-state and write-decision logic for one lane cycle.
  always_comb begin
    state_d      = state_q;
    hold_vld_d   = hold_vld_q;
    hold_data_d  = hold_data_q;
    idle_cnt_d   = idle_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    fifo_write_d = 1'b0;
    fifo_data_d  = '0;
    pkt_done_d   = 1'b0;
    len_d        = len_q;
    ovf_set      = 1'b0;
    tmo_set      = 1'b0;
    idle_inc     = sat_inc16(idle_cnt_q);
    // The timeout only arms once a byte is held; a burst that has not yet
    // delivered anything has nothing to abort.
    timeout_hit  = (rx_timeout != 16'd0) && hold_vld_q && (idle_inc == rx_timeout);

    case (state_q)
      S_IDLE: begin
        if (lane_active) begin
          state_d     = S_RECV;
          idle_cnt_d  = 16'd0;
          byte_cnt_d  = 16'd0;
          hold_vld_d  = lane_valid;
          if (lane_valid) begin
            hold_data_d = lane_data;
          end
        end
      end

      S_RECV: begin
        if (!lane_active) begin
          // Burst ended: the held byte (if any) is the last one.
          state_d    = S_IDLE;
          hold_vld_d = 1'b0;
          if (hold_vld_q) begin
            if (fifo_full) begin
              ovf_set = 1'b1;
              len_d   = byte_cnt_q;
            end else begin
              fifo_write_d = 1'b1;
              fifo_data_d  = {1'b1, hold_data_q};
              pkt_done_d   = 1'b1;
              len_d        = sat_inc16(byte_cnt_q);
            end
          end
        end else if (lane_valid) begin
          idle_cnt_d = 16'd0;
          if (!hold_vld_q) begin
            hold_vld_d  = 1'b1;
            hold_data_d = lane_data;
          end else if (fifo_full) begin
            // Held byte cannot be written: drop it and the rest of the burst.
            ovf_set    = 1'b1;
            len_d      = byte_cnt_q;
            hold_vld_d = 1'b0;
            state_d    = S_DROP;
          end else begin
            fifo_write_d = 1'b1;
            fifo_data_d  = {1'b0, hold_data_q};
            byte_cnt_d   = sat_inc16(byte_cnt_q);
            hold_data_d  = lane_data;
          end
        end else begin
          idle_cnt_d = idle_inc;
          if (timeout_hit) begin
            tmo_set    = 1'b1;
            hold_vld_d = 1'b0;
            state_d    = S_DROP;
            if (fifo_full) begin
              ovf_set = 1'b1;
              len_d   = byte_cnt_q;
            end else begin
              fifo_write_d = 1'b1;
              fifo_data_d  = {1'b1, hold_data_q};
              pkt_done_d   = 1'b1;
              len_d        = sat_inc16(byte_cnt_q);
            end
          end
        end
      end

      S_DROP: begin
        if (!lane_active) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d    = S_IDLE;
        hold_vld_d = 1'b0;
      end
    endcase

    // A new error event in the same cycle wins over a clear request.
    ovf_d = ovf_set | (ovf_q & ~err_clr);
    tmo_d = tmo_set | (tmo_q & ~err_clr);
  end

  // State, hold register, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      hold_vld_q   <= 1'b0;
      hold_data_q  <= '0;
      idle_cnt_q   <= 16'd0;
      byte_cnt_q   <= 16'd0;
      fifo_write_q <= 1'b0;
      fifo_data_q  <= '0;
      pkt_done_q   <= 1'b0;
      ovf_q        <= 1'b0;
      tmo_q        <= 1'b0;
      len_q        <= 16'd0;
    end else begin
      state_q      <= state_d;
      hold_vld_q   <= hold_vld_d;
      hold_data_q  <= hold_data_d;
      idle_cnt_q   <= idle_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      fifo_write_q <= fifo_write_d;
      fifo_data_q  <= fifo_data_d;
      pkt_done_q   <= pkt_done_d;
      ovf_q        <= ovf_d;
      tmo_q        <= tmo_d;
      len_q        <= len_d;
    end
  end

  assign fifo_write   = fifo_write_q;
  assign fifo_data    = fifo_data_q;
  assign pkt_done     = pkt_done_q;
  assign overflow_err = ovf_q;
  assign timeout_err  = tmo_q;
  assign last_pkt_len = len_q;

endmodule
